// File: rtl/ram_uart_dump_pkg.sv
// Shared types and constants for the RAM-window UART dumper.
// The optional checksum trailer is enabled by defining RAM_UART_DUMP_CHECKSUM_EN.
package ram_uart_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    CSUM,
    DONE
  } state_e;

  localparam int unsigned BYTES_PER_WORD   = 4;
  localparam int unsigned BITS_PER_FRAME   = 10;
  localparam int unsigned DEF_ADDR_W       = 10;
  localparam int unsigned DEF_CLKS_PER_BIT = 868;

  // Frame positions: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  localparam logic [3:0] LAST_DATA_POS = 4'(BITS_PER_FRAME - 2);
  localparam logic [3:0] STOP_POS      = 4'(BITS_PER_FRAME - 1);

  // Byte idx of a word, most significant byte first.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ram_uart_dump_if.sv
// Command/status and RAM display-port bundle between the host logic and ram_uart_dump.
// Shared by both builds (RAM_UART_DUMP_CHECKSUM_EN defined or not).
interface ram_uart_dump_if #(
  parameter int unsigned ADDR_W = ram_uart_dump_pkg::DEF_ADDR_W
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] ram_display_addr;
  logic [31:0]       ram_display_data_out;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   words_sent;

  modport master (
    output start, start_addr, word_count, ram_display_data_out,
    input  ram_display_addr, busy, done, words_sent
  );

  modport slave (
    input  start, start_addr, word_count, ram_display_data_out,
    output ram_display_addr, busy, done, words_sent
  );
endinterface

// File: rtl/ram_uart_dump_tx_byte.sv
// 8N1 byte serialiser: owns the baud and bit counters, flags the last cycle of each bit.
// Unaffected by RAM_UART_DUMP_CHECKSUM_EN.
module uart_tx_byte
  import ram_uart_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       bit_end,
  output logic [3:0] bit_pos,
  output logic       byte_done
);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

  logic              active;
  logic [BAUD_W-1:0] baud_cnt;
  logic [7:0]        shift;

  // bit_end/byte_done are registered so they are high during the final cycle of a bit,
  // letting the owner issue the next load on exactly the edge the bit ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active    <= 1'b0;
      baud_cnt  <= '0;
      bit_pos   <= '0;
      shift     <= '0;
      tx        <= 1'b1;
      bit_end   <= 1'b0;
      byte_done <= 1'b0;
    end else if (load) begin
      active    <= 1'b1;
      baud_cnt  <= '0;
      bit_pos   <= '0;
      shift     <= data;
      tx        <= 1'b0;
      bit_end   <= 1'b0;
      byte_done <= 1'b0;
    end else if (active) begin
      bit_end   <= (baud_cnt == BAUD_PRE);
      byte_done <= (baud_cnt == BAUD_PRE) && (bit_pos == STOP_POS);
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_pos == STOP_POS) begin
          active  <= 1'b0;
          bit_pos <= '0;
          tx      <= 1'b1;
        end else begin
          bit_pos <= bit_pos + 4'd1;
          tx      <= (bit_pos == LAST_DATA_POS) ? 1'b1 : shift[bit_pos[2:0]];
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end else begin
      bit_end   <= 1'b0;
      byte_done <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_uart_dump.sv
// Walks a RAM window through the display port and ships each word MSB byte first over UART 8N1.
// Define RAM_UART_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last word.
module ram_uart_dump
  import ram_uart_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned ADDR_W       = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  ram_uart_dump_if.slave bus,
  output logic          tx
);
  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_e            state;
  logic              start_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     count_q;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     remaining;
  logic [31:0]       word_reg;
  logic [1:0]        byte_idx;
  logic [CW-1:0]     words_sent;
  logic              busy;
  logic              done;
`ifdef RAM_UART_DUMP_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic       load_c;
  logic [7:0] byte_c;
  logic       bit_end;
  logic [3:0] bit_pos;
  logic       byte_done;

  assign bus.ram_display_addr = addr;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.words_sent       = words_sent;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .data      (byte_c),
    .tx        (tx),
    .bit_end   (bit_end),
    .bit_pos   (bit_pos),
    .byte_done (byte_done)
  );

  // Next-byte select: loads coincide with the edge ending the previous stop bit.
  always_comb begin
    load_c = 1'b0;
    byte_c = 8'h00;
    case (state)
      FETCH: begin
        load_c = 1'b1;
        byte_c = bus.ram_display_data_out[31:24];
      end
      STOP_BIT: begin
        if (byte_done && (byte_idx != LAST_BYTE)) begin
          load_c = 1'b1;
          byte_c = word_byte(word_reg, byte_idx + 2'd1);
        end
`ifdef RAM_UART_DUMP_CHECKSUM_EN
        else if (byte_done && (remaining == CW'(1))) begin
          load_c = 1'b1;
          byte_c = csum;
        end
`endif
      end
`ifdef RAM_UART_DUMP_CHECKSUM_EN
      IDLE: begin
        if (start_q && (count_q == '0)) begin
          load_c = 1'b1;
          byte_c = 8'h00;
        end
      end
`endif
      default: ;
    endcase
  end

  // start/start_addr/word_count are captured only while idle, so a busy or DONE-cycle start is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      addr       <= '0;
      remaining  <= '0;
      word_reg   <= '0;
      byte_idx   <= '0;
      words_sent <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef RAM_UART_DUMP_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      start_q <= bus.start && (state == IDLE) && !start_q;
      if (bus.start && (state == IDLE) && !start_q) begin
        addr_q  <= bus.start_addr;
        count_q <= bus.word_count;
      end
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start_q) begin
            addr       <= addr_q;
            remaining  <= count_q;
            words_sent <= '0;
            busy       <= 1'b1;
`ifdef RAM_UART_DUMP_CHECKSUM_EN
            csum       <= '0;
            state      <= (count_q == '0) ? CSUM : FETCH;
`else
            if (count_q == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
`endif
          end
        end
        FETCH: begin
          word_reg <= bus.ram_display_data_out;
          byte_idx <= '0;
          state    <= START_BIT;
`ifdef RAM_UART_DUMP_CHECKSUM_EN
          csum     <= csum ^ byte_c;
`endif
        end
        START_BIT: begin
          if (bit_end) state <= DATA_BITS;
        end
        DATA_BITS: begin
          if (bit_end && (bit_pos == LAST_DATA_POS)) state <= STOP_BIT;
        end
        STOP_BIT: begin
          if (byte_done) begin
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= START_BIT;
`ifdef RAM_UART_DUMP_CHECKSUM_EN
              csum     <= csum ^ byte_c;
`endif
            end else begin
              words_sent <= words_sent + CW'(1);
              remaining  <= remaining - CW'(1);
              addr       <= addr + ADDR_W'(1);
              if (remaining == CW'(1)) begin
`ifdef RAM_UART_DUMP_CHECKSUM_EN
                state <= CSUM;
`else
                state <= DONE;
                done  <= 1'b1;
`endif
              end else begin
                state <= FETCH;
              end
            end
          end
        end
        CSUM: begin
          if (byte_done) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
